// File: rtl/ctrl_reg_bank_pkg.sv
// Shared definitions for the control/status register bank: address map helpers,
// the byte-lane merge and the read-mux select encoding.
package ctrl_reg_bank_pkg;

    // Widest register any instance may use; callers cast into and out of this width.
    localparam int MAX_DW = 256;
    localparam int MAX_SW = MAX_DW / 8;

    typedef enum logic [2:0] {
        SEL_CTRL,
        SEL_STAT,
        SEL_PULSE,
        SEL_COUNT,
        SEL_NONE
    } rd_sel_e;

    function automatic int stat_base(input int num_ctrl);
        return num_ctrl;
    endfunction

    function automatic int pulse_addr(input int num_ctrl, input int num_stat);
        return num_ctrl + num_stat;
    endfunction

    function automatic int count_addr(input int num_ctrl, input int num_stat);
        return pulse_addr(num_ctrl, num_stat) + 1;
    endfunction

    function automatic logic [MAX_DW-1:0] merge(input logic [MAX_DW-1:0] old_v,
                                                input logic [MAX_DW-1:0] new_v,
                                                input logic [MAX_SW-1:0] strobe);
        logic [MAX_DW-1:0] res;
        res = old_v;
        for (int b = 0; b < MAX_SW; b++) begin
            if (strobe[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
        end
        return res;
    endfunction

    function automatic rd_sel_e decode(input logic [31:0] addr, input int num_ctrl,
                                       input int num_stat);
        rd_sel_e sel;
        if (addr < unsigned'(num_ctrl))
            sel = SEL_CTRL;
        else if (addr < unsigned'(pulse_addr(num_ctrl, num_stat)))
            sel = SEL_STAT;
        else if (addr == unsigned'(pulse_addr(num_ctrl, num_stat)))
            sel = SEL_PULSE;
        else if (addr == unsigned'(count_addr(num_ctrl, num_stat)))
            sel = SEL_COUNT;
        else
            sel = SEL_NONE;
        return sel;
    endfunction

endpackage

// File: rtl/ctrl_reg_w1c.sv
// One sticky status register: hardware sets, byte-strobed write-one-to-clear,
// set wins over a same-cycle clear.
module ctrl_reg_w1c
    import ctrl_reg_bank_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    clear,
    input  logic [DATA_WIDTH-1:0]   write_data,
    input  logic [DATA_WIDTH/8-1:0] write_strobe,
    input  logic [DATA_WIDTH-1:0]   set,
    output logic [DATA_WIDTH-1:0]   value
);

    logic [DATA_WIDTH-1:0] clear_mask;

    always_comb begin
        clear_mask = '0;
        if (clear)
            clear_mask = DATA_WIDTH'(merge('0, MAX_DW'(write_data), MAX_SW'(write_strobe)));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) value <= '0;
        else        value <= (value & ~clear_mask) | set;
    end

endmodule

// File: rtl/ctrl_reg_bank.sv
// Register bank: RW control words, W1C status words, self-clearing pulse word and
// a loadable event counter behind one byte-strobed bus with a 1-cycle read path.
module ctrl_reg_bank
    import ctrl_reg_bank_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 8,   // at most 32
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_CTRL   = 4,
    parameter int                    NUM_STAT   = 2,
    parameter logic [DATA_WIDTH-1:0] CTRL_RESET = '0
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [ADDR_WIDTH-1:0]          address,
    input  logic                           write_enable,
    input  logic [DATA_WIDTH-1:0]          write_data,
    input  logic [DATA_WIDTH/8-1:0]        write_strobe,
    input  logic                           read_enable,
    output logic [DATA_WIDTH-1:0]          read_data,
    output logic                           read_valid,
    output logic                           access_error,
    output logic [NUM_CTRL*DATA_WIDTH-1:0] ctrl_out,
    input  logic [NUM_STAT*DATA_WIDTH-1:0] status_set,
    output logic                           status_irq,
    output logic [DATA_WIDTH-1:0]          pulse_out,
    input  logic                           count_inc,
    output logic [DATA_WIDTH-1:0]          count_value
);

    localparam int STAT_BASE = stat_base(NUM_CTRL);

    logic [31:0]                          addr_u;
    rd_sel_e                              sel;
    logic [NUM_CTRL-1:0]                  ctrl_hit;
    logic [NUM_STAT-1:0]                  stat_hit;
    logic [NUM_CTRL-1:0][DATA_WIDTH-1:0]  ctrl_q;
    logic [NUM_STAT-1:0][DATA_WIDTH-1:0]  stat_set;
    logic [DATA_WIDTH-1:0]                stat_q [NUM_STAT];
    logic [DATA_WIDTH-1:0]                count_q;
    logic [DATA_WIDTH-1:0]                rd_mux;
    logic                                 irq;

    function automatic logic [DATA_WIDTH-1:0] merge_dw(input logic [DATA_WIDTH-1:0]   o,
                                                       input logic [DATA_WIDTH-1:0]   n,
                                                       input logic [DATA_WIDTH/8-1:0] s);
        return DATA_WIDTH'(merge(MAX_DW'(o), MAX_DW'(n), MAX_SW'(s)));
    endfunction

    assign addr_u   = 32'(address);
    assign sel      = decode(addr_u, NUM_CTRL, NUM_STAT);
    assign stat_set = status_set;

    always_comb begin
        ctrl_hit = '0;
        stat_hit = '0;
        for (int i = 0; i < NUM_CTRL; i++)
            ctrl_hit[i] = write_enable && (addr_u == unsigned'(i));
        for (int i = 0; i < NUM_STAT; i++)
            stat_hit[i] = write_enable && (addr_u == unsigned'(STAT_BASE + i));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ctrl_q <= {NUM_CTRL{CTRL_RESET}};
        end else begin
            for (int i = 0; i < NUM_CTRL; i++)
                if (ctrl_hit[i]) ctrl_q[i] <= merge_dw(ctrl_q[i], write_data, write_strobe);
        end
    end

    assign ctrl_out = ctrl_q;

    for (genvar g = 0; g < NUM_STAT; g++) begin : g_stat
        ctrl_reg_w1c #(.DATA_WIDTH(DATA_WIDTH)) u_stat (
            .clock        (clock),
            .reset        (reset),
            .clear        (stat_hit[g]),
            .write_data   (write_data),
            .write_strobe (write_strobe),
            .set          (stat_set[g]),
            .value        (stat_q[g])
        );
    end

    always_comb begin
        irq = 1'b0;
        for (int i = 0; i < NUM_STAT; i++) irq = irq | (|stat_q[i]);
    end

    assign status_irq = irq;

    // Unstrobed lanes of a pulse write stay low rather than holding anything.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            pulse_out <= '0;
        else if (write_enable && sel == SEL_PULSE)
            pulse_out <= merge_dw('0, write_data, write_strobe);
        else
            pulse_out <= '0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            count_q <= '0;
        else if (write_enable && sel == SEL_COUNT)
            count_q <= merge_dw(count_q, write_data, write_strobe);
        else if (count_inc)
            count_q <= count_q + DATA_WIDTH'(1);
    end

    assign count_value = count_q;

    // Mux sees pre-edge state, so same-cycle writes/increments are not visible to a read.
    always_comb begin
        rd_mux = '0;
        case (sel)
            SEL_CTRL:
                for (int i = 0; i < NUM_CTRL; i++)
                    if (addr_u == unsigned'(i)) rd_mux = ctrl_q[i];
            SEL_STAT:
                for (int i = 0; i < NUM_STAT; i++)
                    if (addr_u == unsigned'(STAT_BASE + i)) rd_mux = stat_q[i];
            SEL_COUNT: rd_mux = count_q;
            default:   rd_mux = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            read_data    <= '0;
            read_valid   <= 1'b0;
            access_error <= 1'b0;
        end else begin
            read_valid   <= read_enable;
            access_error <= (read_enable || write_enable) && (sel == SEL_NONE);
            if (read_enable) read_data <= rd_mux;
        end
    end

endmodule

// File: doc/ctrl_reg_bank.md
Name: ctrl_reg_bank

Overview:
Parametrised successor to the single-address control register block: a bank of NUM_CTRL read/write control registers, NUM_STAT sticky write-one-to-clear status registers, a self-clearing pulse register and a loadable event counter.
- Access is through one shared write/read bus with byte strobes, a registered read path with read_valid, and an error flag for unmapped addresses.
- Sits between a bus-master bridge and datapath blocks that need pipe enables, interrupt status and event counts.

Parameters:
ADDR_WIDTH, 8, word-address width of the bus.
DATA_WIDTH, 32, register width; must be a multiple of 8.
NUM_CTRL, 4, number of RW control registers (1..16).
NUM_STAT, 2, number of W1C status registers (1..8).
CTRL_RESET, 0, reset value loaded into every control register.

Ports:
clock  in  1  bus and register clock.
reset  in  1  asynchronous, active-low reset.
address  in  ADDR_WIDTH  word address of the access.
write_enable  in  1  write strobe; one write per cycle.
write_data  in  DATA_WIDTH  write payload.
write_strobe  in  DATA_WIDTH/8  byte enables for the write.
read_enable  in  1  read request.
read_data  out  DATA_WIDTH  registered read result.
read_valid  out  1  high one cycle after an accepted read.
access_error  out  1  one-cycle pulse on access to an unmapped address.
ctrl_out  out  NUM_CTRL*DATA_WIDTH  concatenated control registers; reg 0 in the LSBs.
status_set  in  NUM_STAT*DATA_WIDTH  per-bit hardware set requests.
status_irq  out  1  OR of all status bits.
pulse_out  out  DATA_WIDTH  one-cycle pulse bits.
count_inc  in  1  event-counter increment.
count_value  out  DATA_WIDTH  current counter value.

Behaviour:
Address map (word addresses):
- 0..NUM_CTRL-1: CTRL.
- NUM_CTRL..NUM_CTRL+NUM_STAT-1: STAT.
- P = NUM_CTRL+NUM_STAT: PULSE.
- P+1: COUNT.
- Any higher address is unmapped.

Reset (reset low, asynchronous):
- CTRL = CTRL_RESET; STAT = 0; counter = 0.
- pulse_out = 0; read_data = 0; read_valid = 0; access_error = 0.

Writes:
- All writes take effect on the clock edge after write_enable is sampled.
- CTRL: byte lane b is updated only when write_strobe[b] = 1.
- STAT: each written 1 in a strobed lane clears the corresponding bit.
- STAT hardware set: status_set bits set STAT bits every cycle. On a simultaneous set and clear of the same bit, set wins.
- PULSE: pulse_out = strobed write_data for exactly one cycle, then returns to 0. Back-to-back writes give back-to-back pulses.
- COUNT: loads strobed bytes. Unstrobed bytes keep their current value and the increment is not applied that cycle (write wins over count_inc).

Counter:
- Increments by 1 per cycle while count_inc = 1.
- Wraps from all-ones to 0 with no flag.

Reads:
- read_enable sampled at edge N gives read_data and read_valid = 1 at edge N+1. Latency is fixed at 1.
- Read values: CTRL returns its value; STAT returns its value; PULSE returns 0; COUNT returns the value before any same-cycle increment or write.
- A simultaneous read and write to the same address returns the pre-write value.
- read_data holds its last value while read_valid = 0.

Unmapped access:
- Read or write to an unmapped address gives access_error = 1 for one cycle, aligned with read_valid for reads.
- An unmapped read returns read_data = 0 with read_valid = 1.
- An unmapped write has no state effect.

status_irq is combinational from the STAT registers (no extra latency).

A reset asserted mid-access aborts the access: read_valid and pulse_out are forced to 0 immediately.

Decomposition:
- Package ctrl_reg_bank_pkg holds:
  - localparam functions for the STAT_BASE, PULSE_ADDR and COUNT_ADDR offsets;
  - the byte-merge function merge(old, new, strobe);
  - the read-mux select encoding.
- Natural sub-module: ctrl_reg_w1c, one status register with byte-strobed W1C and set-priority, instantiated NUM_STAT times.
- CTRL, PULSE, COUNT and the read mux stay in the top module.

Test Plan:
- Reset, then read all CTRL/STAT/COUNT addresses -> CTRL = CTRL_RESET, STAT = 0, COUNT = 0; read_valid exactly 1 cycle after each read_enable.
- Write 0xDEADBEEF with strobe 0b0101 to CTRL1 (reset 0) -> ctrl_out[63:32] = 0x00AD00EF; readback matches.
- Pulse status_set bit 3 of STAT0; W1C 0x8 with status_set bit 3 held high that cycle -> bit stays 1, status_irq = 1. Next W1C 0x8 -> bit clears, status_irq = 0.
- Write 0x5 to PULSE -> pulse_out = 0x5 for one cycle then 0; PULSE read returns 0.
- Load COUNT = 0xFFFFFFFE with count_inc held high -> load takes priority, then counter reads 0xFFFFFFFF, then 0 (wrap).
- Read and write address 0xFF (unmapped, defaults) -> access_error pulses once each; read_data = 0; no register changes. Assert reset mid-read -> read_valid = 0 immediately.
